// File: rtl/ercm_pipe.sv
// ercm_pipe: 3-stage valid/ready OR-tree approximate multiplier with error compensation.
// Define ERCM_STATS_EN to build the saturating approximate-vs-exact mismatch counter.
module ercm_pipe #(
    parameter int W        = 8,
    parameter int COMP_LSB = W / 2,
    parameter int CUTW     = $clog2(2 * W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      dat_in_a,
    input  logic [W-1:0]      dat_in_b,
    input  logic              appx_mode,
    input  logic [CUTW-1:0]   appx_cut,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    dat_o,
    output logic [15:0]       stat_err_cnt,
    input  logic              stat_clr
);
    localparam int PW   = 2 * W;
    localparam int LVLS = $clog2(W);
    localparam logic [PW-1:0] LSB_MASK = (PW'(1) << COMP_LSB) - PW'(1);

    logic en;
    logic v1, v2, v3;

    logic [W-1:0]    a1, b1;
    logic            mode1;
    logic [CUTW-1:0] cut1;

    logic [PW-1:0]   s2, comp2, exact2;
    logic            mode2;
    logic [CUTW-1:0] cut2;

    logic            mis3;

    logic [PW-1:0]   tree [LVLS+1][W];
    logic [PW-1:0]   and_terms;
    logic [PW-1:0]   s_comb, v_comb, exact_comb;

    logic [CUTW-1:0] cut_sat;
    logic [PW-1:0]   hi_mask, appx_comb, res_comb;

    assign en        = ~v3 | out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    // OR-tree over the partial-product rows; every pair's AND term feeds the compensation vector.
    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < W; i++) begin
                tree[l][i] = '0;
            end
        end
        and_terms = '0;
        for (int i = 0; i < W; i++) begin
            tree[0][i] = {{W{1'b0}}, ({W{a1[i]}} & b1)} << i;
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int k = 0; k < (W >> (l + 1)); k++) begin
                tree[l+1][k] = tree[l][2*k] | tree[l][2*k+1];
                and_terms    = and_terms | (tree[l][2*k] & tree[l][2*k+1]);
            end
        end
    end

    assign s_comb     = tree[LVLS][0];
    assign v_comb     = and_terms & ~LSB_MASK;
    assign exact_comb = {{W{1'b0}}, a1} * {{W{1'b0}}, b1};

    // Below the cut the bits are OR-merged; above it S and V are added, low bits are zero so no carry leaks down.
    assign cut_sat   = (cut2 > CUTW'(PW)) ? CUTW'(PW) : cut2;
    assign hi_mask   = {PW{1'b1}} << cut_sat;
    assign appx_comb = ((s2 | comp2) & ~hi_mask) | ((s2 & hi_mask) + (comp2 & hi_mask));
    assign res_comb  = mode2 ? appx_comb : exact2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            mode1  <= 1'b0;
            cut1   <= '0;
            s2     <= '0;
            comp2  <= '0;
            exact2 <= '0;
            mode2  <= 1'b0;
            cut2   <= '0;
            dat_o  <= '0;
            mis3   <= 1'b0;
        end else if (en) begin
            v1     <= in_valid;
            a1     <= dat_in_a;
            b1     <= dat_in_b;
            mode1  <= appx_mode;
            cut1   <= appx_cut;
            v2     <= v1;
            s2     <= s_comb;
            comp2  <= v_comb;
            exact2 <= exact_comb;
            mode2  <= mode1;
            cut2   <= cut1;
            v3     <= v2;
            dat_o  <= res_comb;
            mis3   <= mode2 & (appx_comb != exact2);
        end
    end

`ifdef ERCM_STATS_EN
    logic [15:0] err_cnt;

    // Clear has priority over a mismatch retiring in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            err_cnt <= '0;
        end else if (v3 && out_ready && mis3 && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign stat_err_cnt = err_cnt;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_err_cnt    = 16'h0000;
`endif

endmodule
